// File: rtl/cpu_pkg.sv
// Shared IF-stage types and constants.
// Used by the PC generator and its redirect buffer.
package cpu_pkg;

  typedef enum logic {
    S_BOOT,
    S_RUN
  } state_t;

  localparam int STALL_PC = 0;

  function automatic int pc_align_bits(input int step);
    return (step <= 1) ? 0 : $clog2(step);
  endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// Holds one redirect that arrived while the PC could not move.
// Exceptions overwrite anything; branches never displace an exception.
module pc_redirect_buf
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              consume,
  input  logic              exc,
  input  logic [ADDR_W-1:0] exc_addr,
  input  logic              br,
  input  logic [ADDR_W-1:0] br_addr,
  output logic              pend_v,
  output logic              pend_exc,
  output logic [ADDR_W-1:0] pend_addr,
  output logic              exc_take,
  output logic              br_take
);

  assign exc_take = hold & exc;
  assign br_take  = hold & ~exc & br & ~(pend_v & pend_exc);

  // Capture while held, clear when the PC consumes the entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_v    <= 1'b0;
      pend_exc  <= 1'b0;
      pend_addr <= '0;
    end else if (exc_take) begin
      pend_v    <= 1'b1;
      pend_exc  <= 1'b1;
      pend_addr <= exc_addr;
    end else if (br_take) begin
      pend_v    <= 1'b1;
      pend_exc  <= 1'b0;
      pend_addr <= br_addr;
    end else if (consume) begin
      pend_v    <= 1'b0;
      pend_exc  <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator for instruction fetch.
// Boot/run FSM, next-pc priority mux and target alignment.
module pc_gen
  import cpu_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int                STEP      = 4,
  parameter int                STALL_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               br,
  input  logic [ADDR_W-1:0]  br_addr,
  input  logic               exc,
  input  logic [ADDR_W-1:0]  exc_addr,
  output logic [ADDR_W-1:0]  pc,
  output logic               ce,
  output logic               redir,
  output logic               misalign
);

  localparam int AB = pc_align_bits(STEP);
  localparam logic [ADDR_W-1:0] LOW = ADDR_W'((1 << AB) - 1);

  state_t state;

  logic              hold;
  logic              run;
  logic              exc_bad;
  logic              br_bad;
  logic [ADDR_W-1:0] exc_m;
  logic [ADDR_W-1:0] br_m;
  logic              pend_v;
  logic              pend_exc;
  logic [ADDR_W-1:0] pend_addr;
  logic              exc_take;
  logic              br_take;
  logic              hold_mis;
  logic [ADDR_W-1:0] nxt;
  logic              take;
  logic              run_mis;
  logic              unused_stall;

  assign unused_stall = ^stall;

  assign hold = (state == S_BOOT) | stall[STALL_PC];
  assign run  = (state == S_RUN) & ~stall[STALL_PC];

  assign exc_m   = exc_addr & ~LOW;
  assign br_m    = br_addr & ~LOW;
  assign exc_bad = |(exc_addr & LOW);
  assign br_bad  = |(br_addr & LOW);

  assign hold_mis = (exc_take & exc_bad) | (br_take & br_bad);

  pc_redirect_buf #(
    .ADDR_W(ADDR_W)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .hold     (hold),
    .consume  (run),
    .exc      (exc),
    .exc_addr (exc_m),
    .br       (br),
    .br_addr  (br_m),
    .pend_v   (pend_v),
    .pend_exc (pend_exc),
    .pend_addr(pend_addr),
    .exc_take (exc_take),
    .br_take  (br_take)
  );

  // Next-pc priority: exception, branch, buffered, sequential.
  always_comb begin
    nxt     = pc + ADDR_W'(STEP);
    take    = 1'b0;
    run_mis = 1'b0;
    if (exc) begin
      nxt     = exc_m;
      take    = 1'b1;
      run_mis = exc_bad;
    end else if (br) begin
      nxt     = br_m;
      take    = 1'b1;
      run_mis = br_bad;
    end else if (pend_v) begin
      nxt     = pend_addr;
      take    = 1'b1;
    end
  end

  // Boot/run FSM with registered pc and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_BOOT;
      pc       <= RESET_VEC;
      ce       <= 1'b0;
      redir    <= 1'b0;
      misalign <= 1'b0;
    end else begin
      case (state)
        S_BOOT: begin
          state    <= S_RUN;
          ce       <= 1'b1;
          redir    <= 1'b0;
          misalign <= hold_mis;
        end
        S_RUN: begin
          if (stall[STALL_PC]) begin
            redir    <= 1'b0;
            misalign <= hold_mis;
          end else begin
            pc       <= nxt;
            redir    <= take;
            misalign <= run_mis;
          end
        end
        default: state <= S_BOOT;
      endcase
    end
  end

endmodule
